// File: rtl/viterbi_ber_ctrl.sv
// BER test sequencer: PRBS frame source, channel error-mask scheduler, tail flush,
// decoder drain and latency-aligned checker. `define BER_BURST_EN for burst errors.
module viterbi_ber_ctrl #(
  parameter int          FRAME_LEN  = 256,
  parameter int          ERR_PERIOD = 16,
  parameter int          ENC_LAT    = 1,
  parameter int          DEC_LAT    = 32,
  parameter int          TAIL       = 2,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int          BURST_LEN  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        err_en,
  input  logic        dec_bit_i,
  output logic        enc_bit_o,
  output logic        enc_en_o,
  output logic [1:0]  err_mask_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] sym_err_ct_o,
  output logic [15:0] inj_bit_ct_o,
  output logic [15:0] bit_err_ct_o,
  output logic [15:0] chk_ct_o,
  output logic [2:0]  dbg_state
);

  // start is a one-cycle request with no ready: it is taken only in IDLE or DONE,
  // and a pulse seen while busy_o is high is dropped without effect.

  generate
    if (ENC_LAT < 1) begin : g_enc_lat_chk
      $error("ENC_LAT must be >= 1");
    end
    if (DEC_LAT < 1) begin : g_dec_lat_chk
      $error("DEC_LAT must be >= 1");
    end
    if (BURST_LEN < 1) begin : g_burst_min_chk
      $error("BURST_LEN must be >= 1");
    end
`ifdef BER_BURST_EN
    if (BURST_LEN > ERR_PERIOD) begin : g_burst_chk
      $error("BURST_LEN must not exceed ERR_PERIOD");
    end
`endif
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_FLUSH = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic        err_lat;
  logic [15:0] ph_cnt;
  logic [15:0] per_cnt;
  logic [1:0]  k_mod;
  logic [1:0]  mask_pipe [ENC_LAT];
  logic [1:0]  dl        [DEC_LAT];

  logic [15:0] lfsr_nxt;
  logic [15:0] per_nxt;
  logic [1:0]  k_inc;
  logic [1:0]  mask_out;
  logic [1:0]  tap;

  assign lfsr_nxt  = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign per_nxt   = (per_cnt == 16'(ERR_PERIOD - 1)) ? 16'd0 : per_cnt + 16'd1;
  assign k_inc     = (k_mod == 2'd2) ? 2'd0 : k_mod + 2'd1;
  assign mask_out  = mask_pipe[ENC_LAT-1];
  assign tap       = dl[DEC_LAT-1];
  assign dbg_state = state;

  function automatic logic errored(input logic [15:0] pos);
`ifdef BER_BURST_EN
    return pos < 16'(BURST_LEN);
`else
    return pos == 16'd0;
`endif
  endfunction

  function automatic logic [1:0] mask_of(input logic [1:0] k);
    case (k)
      2'd0:    return 2'b11;
      2'd1:    return 2'b10;
      default: return 2'b01;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic [1:0] amt);
    logic [16:0] sum;
    sum = {1'b0, v} + {15'd0, amt};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      lfsr         <= SEED;
      err_lat      <= 1'b0;
      ph_cnt       <= '0;
      per_cnt      <= '0;
      k_mod        <= '0;
      enc_bit_o    <= 1'b0;
      enc_en_o     <= 1'b0;
      err_mask_o   <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      sym_err_ct_o <= '0;
      inj_bit_ct_o <= '0;
      bit_err_ct_o <= '0;
      chk_ct_o     <= '0;
      for (int i = 0; i < ENC_LAT; i++) mask_pipe[i] <= '0;
      for (int i = 0; i < DEC_LAT; i++) dl[i] <= '0;
    end else begin
      // Mask path: stage 0 is loaded alongside enc_bit_o, so the mask reaches
      // the channel exactly ENC_LAT cycles after its data bit.
      mask_pipe[0] <= 2'b00;
      for (int i = 1; i < ENC_LAT; i++) mask_pipe[i] <= mask_pipe[i-1];
      err_mask_o <= mask_out;
      if (mask_out != 2'b00) begin
        sym_err_ct_o <= sat_inc(sym_err_ct_o, 2'd1);
        inj_bit_ct_o <= sat_inc(inj_bit_ct_o, {1'b0, mask_out[1]} + {1'b0, mask_out[0]});
      end

      // Reference path: {valid, bit} of each issued bit, tapped DEC_LAT later.
      dl[0] <= {state == S_RUN, enc_bit_o};
      for (int i = 1; i < DEC_LAT; i++) dl[i] <= dl[i-1];
      if (tap[1]) begin
        chk_ct_o <= sat_inc(chk_ct_o, 2'd1);
        if (tap[0] != dec_bit_i) bit_err_ct_o <= sat_inc(bit_err_ct_o, 2'd1);
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state        <= S_RUN;
            lfsr         <= SEED;
            enc_bit_o    <= SEED[0];
            enc_en_o     <= 1'b1;
            busy_o       <= 1'b1;
            done_o       <= 1'b0;
            err_lat      <= err_en;
            ph_cnt       <= '0;
            per_cnt      <= '0;
            sym_err_ct_o <= '0;
            inj_bit_ct_o <= '0;
            bit_err_ct_o <= '0;
            chk_ct_o     <= '0;
            if (err_en && errored(16'd0)) begin
              mask_pipe[0] <= mask_of(2'd0);
              k_mod        <= 2'd1;
            end else begin
              k_mod        <= 2'd0;
            end
          end
        end
        S_RUN: begin
          if (ph_cnt == 16'(FRAME_LEN - 1)) begin
            ph_cnt    <= '0;
            enc_bit_o <= 1'b0;
            if (TAIL == 0) begin
              state    <= S_DRAIN;
              enc_en_o <= 1'b0;
            end else begin
              state    <= S_FLUSH;
            end
          end else begin
            ph_cnt    <= ph_cnt + 16'd1;
            lfsr      <= lfsr_nxt;
            enc_bit_o <= lfsr_nxt[0];
            per_cnt   <= per_nxt;
            if (err_lat && errored(per_nxt)) begin
              mask_pipe[0] <= mask_of(k_mod);
              k_mod        <= k_inc;
            end
          end
        end
        S_FLUSH: begin
          if (ph_cnt == 16'(TAIL - 1)) begin
            state    <= S_DRAIN;
            enc_en_o <= 1'b0;
            ph_cnt   <= '0;
          end else begin
            ph_cnt   <= ph_cnt + 16'd1;
          end
        end
        S_DRAIN: begin
          if (ph_cnt == 16'(DEC_LAT - 1)) begin
            state  <= S_DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            ph_cnt <= '0;
          end else begin
            ph_cnt <= ph_cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
